// File: rtl/accum_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | accum_seq_pkg                                                         |
// | Shared state encoding and limits for the accumulate/count sequencer.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package accum_seq_pkg;

  localparam int NS_MAX = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/accum_stall_timer.sv
// +-----------------------------------------------------------------------+
// | accum_stall_timer                                                     |
// | Counts consecutive non-accept ACCUM cycles; flags the final one.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module accum_stall_timer #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic term
);

  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TW-1:0] c_LAST = c_TW'(TIMEOUT_CYC - 1);

  logic [c_TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Asserted in the stall cycle that makes the count reach TIMEOUT_CYC.
  assign term = inc && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/accum_seq_ctrl.sv
// +-----------------------------------------------------------------------+
// | accum_seq_ctrl                                                        |
// | Run sequencer for the accumulator/count datapath (CLEAR, NUM_SAMPLES  |
// | beats, DONE). Optional stall timeout under macro ACCUM_TIMEOUT_EN.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             clr,
  output logic             adder_en,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > NS_MAX)) begin : g_bad_ns
    $error("accum_seq_ctrl: NUM_SAMPLES must be 1..%0d", NS_MAX);
  end
  if ((NUM_SAMPLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("accum_seq_ctrl: CNT_W too narrow for NUM_SAMPLES");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("accum_seq_ctrl: TIMEOUT_CYC must be >= 1");
  end

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_SAMPLES - 1);

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_stall_term;

  assign in_ready = (r_state == S_ACCUM) && !abort;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == S_CLEAR) || (r_state == S_ACCUM);
  assign done     = (r_state == S_DONE) && !abort;

`ifdef ACCUM_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_inc;

  // Held clear outside ACCUM, so every entry into ACCUM starts from zero.
  assign w_tmr_clr = (r_state != S_ACCUM) || w_accept;
  assign w_tmr_inc = (r_state == S_ACCUM) && !w_accept && !abort;

  accum_stall_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_stall_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (w_tmr_clr),
    .inc   (w_tmr_inc),
    .term  (w_stall_term)
  );

  assign err = (r_state == S_ERR);
`else
  assign w_stall_term = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    clr      = 1'b0;
    adder_en = 1'b0;
    cnt_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        clr      = 1'b1;
        adder_en = 1'b1;
        cnt_en   = 1'b1;
        w_next   = S_ACCUM;
      end
      S_ACCUM: begin
        if (w_accept) begin
          adder_en = 1'b1;
          cnt_en   = 1'b1;
          if (cnt_q == c_LAST) w_next = S_DONE;
        end else if (w_stall_term) begin
          w_next = S_ERR;
        end
      end
      S_DONE: begin
        w_next = start ? S_CLEAR : S_IDLE;
      end
`ifdef ACCUM_TIMEOUT_EN
      S_ERR: begin
        if (start) w_next = S_CLEAR;
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Abort overrides everything, including the CLEAR-cycle enables.
    if (abort) begin
      w_next   = S_IDLE;
      clr      = 1'b0;
      adder_en = 1'b0;
      cnt_en   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_accum_seq_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_accum_seq_ctrl                                                     |
// | Directed bench: three sequencers (NUM_SAMPLES 4, 1, 16) each closing  |
// | the cnt_q loop through a behavioural accumulator/count datapath.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_accum_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] abort;
  logic [2:0] in_valid;
  wire  [2:0] in_ready;
  wire  [2:0] clr;
  wire  [2:0] adder_en;
  wire  [2:0] cnt_en;
  wire  [2:0] busy;
  wire  [2:0] done;
  wire  [2:0] err;
  wire  [18:0] acc_w [3];
  wire  [3:0]  cnt_w [3];
  wire  [31:0] ae_w  [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [18:0] acc;
    logic [3:0]  cnt;
    logic [31:0] ae;

    accum_seq_ctrl #(
      .NUM_SAMPLES ((g == 0) ? 4 : ((g == 1) ? 1 : 16)),
      .CNT_W       (4),
      .TIMEOUT_CYC (8)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .abort    (abort[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .cnt_q    (cnt),
      .clr      (clr[g]),
      .adder_en (adder_en[g]),
      .cnt_en   (cnt_en[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .err      (err[g])
    );

    // Beat k (1-based) carries data value k, so a full run sums 1+2+..+N.
    always @(posedge clk) begin
      if (rst) begin
        acc <= '0;
        cnt <= '0;
        ae  <= '0;
      end else begin
        if (adder_en[g]) acc <= clr[g] ? 19'd0 : acc + 19'(cnt) + 19'd1;
        if (cnt_en[g])   cnt <= clr[g] ? 4'd0 : cnt + 4'd1;
        if (adder_en[g] && !clr[g]) ae <= ae + 32'd1;
      end
    end

    assign acc_w[g] = acc;
    assign cnt_w[g] = cnt;
    assign ae_w[g]  = ae;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run on instance k; in_valid drops for s_len cycles once s_after
  // beats are in, and start is re-pulsed in relative cycle s_at.
  task automatic do_run(input int k, input int s_after, input int s_len, input int s_at,
                        output int lat, output bit rdy_ok);
    int beats  = 0;
    int stalls = 0;
    int n      = 0;
    lat    = -1;
    rdy_ok = 1'b1;
    start[k]    = 1'b1;
    in_valid[k] = 1'b1;
    while (lat < 0 && n < 80) begin
      if (in_ready[k] && in_valid[k]) beats++;
      tick();
      n++;
      start[k] = (n == s_at);
      if (done[k]) begin
        lat = n;
      end else if (s_len > 0 && beats == s_after && stalls < s_len) begin
        in_valid[k] = 1'b0;
        stalls++;
        if (!in_ready[k]) rdy_ok = 1'b0;
      end else begin
        in_valid[k] = 1'b1;
      end
    end
    in_valid[k] = 1'b0;
    start[k]    = 1'b0;
  endtask

  task automatic run_check(input string tag, input int k, input int s_after, input int s_len,
                           input int s_at, input int exp_lat, input int exp_sum, input int exp_pulses);
    int          lat;
    bit          ok;
    logic [31:0] ae0;
    ae0 = ae_w[k];
    do_run(k, s_after, s_len, s_at, lat, ok);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sum"}, 32'(acc_w[k]), 32'(exp_sum));
    check({tag, "_pulses"}, ae_w[k] - ae0, 32'(exp_pulses));
    check({tag, "_err"}, 32'(err[k]), 32'd0);
    if (s_len > 0) check({tag, "_ready_in_stall"}, 32'(ok), 32'd1);
    tick();
    check({tag, "_done_one_cycle"}, 32'(done[k]), 32'd0);
    check({tag, "_idle_after"}, 32'(busy[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dseen;
    rst      = 1'b1;
    start    = '0;
    abort    = '0;
    in_valid = '0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_busy%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("reset_done%0d", k), 32'(done[k]), 32'd0);
      check($sformatf("reset_ready%0d", k), 32'(in_ready[k]), 32'd0);
      check($sformatf("reset_en%0d", k), 32'({clr[k], adder_en[k], cnt_en[k], err[k]}), 32'd0);
    end
    rst = 1'b0;
    tick();

    run_check("basic4", 0, 0, 0, -1, 6, 10, 4);
    run_check("stall3", 0, 2, 3, -1, 9, 10, 4);

    // Abort after two accepted beats.
    start[0] = 1'b1; in_valid[0] = 1'b1;
    tick(); start[0] = 1'b0;
    tick(); tick(); tick();
    abort[0] = 1'b1;
    #1;
    check("abort_ready", 32'(in_ready[0]), 32'd0);
    check("abort_enables", 32'({clr[0], adder_en[0], cnt_en[0]}), 32'd0);
    tick();
    abort[0] = 1'b0; in_valid[0] = 1'b0;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_count", 32'(cnt_w[0]), 32'd2);
    dseen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done[0]) dseen++;
    end
    check("abort_no_done", 32'(dseen), 32'd0);
    run_check("after_abort", 0, 0, 0, -1, 6, 10, 4);

    run_check("start_in_accum", 0, 0, 0, 3, 6, 10, 4);

    // Reset in the middle of ACCUM.
    start[0] = 1'b1; in_valid[0] = 1'b1;
    tick(); start[0] = 1'b0;
    tick(); tick();
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy[0]), 32'd0);
    check("rst_mid_outs", 32'({in_ready[0], adder_en[0], cnt_en[0], done[0]}), 32'd0);
    in_valid[0] = 1'b0;
    tick();

    run_check("ns1", 1, 0, 0, -1, 3, 1, 1);
    run_check("ns16", 2, 0, 0, -1, 18, 136, 16);

    // Back-to-back: start during DONE goes straight to CLEAR.
    begin
      int  lat;
      bit  ok;
      do_run(0, 0, 0, -1, lat, ok);
      check("b2b_first_latency", 32'(lat), 32'd6);
      start[0] = 1'b1; in_valid[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      check("b2b_clear", 32'({clr[0], busy[0]}), 32'd3);
      n = 0;
      while (!done[0] && n < 40) begin
        tick();
        n++;
      end
      check("b2b_second_latency", 32'(n), 32'd5);
      check("b2b_sum", 32'(acc_w[0]), 32'd10);
      in_valid[0] = 1'b0;
      tick();
    end

`ifdef ACCUM_TIMEOUT_EN
    start[0] = 1'b1; in_valid[0] = 1'b0;
    tick(); start[0] = 1'b0;
    repeat (8) tick();
    check("timeout_err_before", 32'(err[0]), 32'd0);
    check("timeout_ready_before", 32'(in_ready[0]), 32'd1);
    tick();
    check("timeout_err", 32'(err[0]), 32'd1);
    check("timeout_ready", 32'(in_ready[0]), 32'd0);
    tick();
    check("timeout_err_held", 32'(err[0]), 32'd1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("timeout_restart_clear", 32'({clr[0], busy[0]}), 32'd3);
    check("timeout_restart_err", 32'(err[0]), 32'd0);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
`else
    run_check("long_stall", 0, 2, 12, -1, 18, 10, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
